// File: rtl/floo_pkg.sv
// floo_pkg: shared types for the FlooNoC router datapath.
//   wh_demux_state_e - wormhole demux lock state
//   wh_hdr_t/wh_flit_t - default flit layout (header carries the packet tail flag)
//   idx_width()      - bits needed to index n items (at least 1)
package floo_pkg;

    typedef enum logic [1:0] {
        WhIdle,
        WhLocked,
        WhDrop
    } wh_demux_state_e;

    typedef struct packed {
        logic last;
    } wh_hdr_t;

    typedef struct packed {
        wh_hdr_t     hdr;
        logic [15:0] payload;
    } wh_flit_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/floo_wormhole_demux.sv
// floo_wormhole_demux: steers whole packets from one input stream to one of
// NumRoutes output streams. The route is taken from sel_i on the head flit and
// held until the flit with hdr.last handshakes. Out-of-range routes swallow
// the packet and pulse drop_o on its tail.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   valid_i/ready_o    input handshake
//   data_i             input flit (broadcast to every data_o lane)
//   sel_i              route for the packet, looked at on head flits only
//   valid_o/ready_i    per-route output handshake
//   data_o             per-route flit
//   drop_o             tail handshake of a discarded packet
module floo_wormhole_demux
    import floo_pkg::*;
#(
    parameter int unsigned NumRoutes = 2,
    parameter type         flit_t    = wh_flit_t,
    localparam int unsigned SelWidth = idx_width(NumRoutes) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  flit_t                 data_i,
    input  logic [SelWidth-1:0]   sel_i,
    output logic [NumRoutes-1:0]  valid_o,
    input  logic [NumRoutes-1:0]  ready_i,
    output flit_t [NumRoutes-1:0] data_o,
    output logic                  drop_o
);

    wh_demux_state_e     state_d, state_q;
    logic [SelWidth-1:0] sel_d, sel_q;
    logic [SelWidth-1:0] eff;
    logic                route_ok;
    logic                hs;
    logic                last;

    always_comb begin
        for (int unsigned k = 0; k < NumRoutes; k++) begin
            data_o[k] = data_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        valid_o  = '0;
        ready_o  = 1'b0;
        drop_o   = 1'b0;
        last     = data_i.hdr.last;

        // While locked the stored route wins; otherwise the head flit's selector.
        eff      = (state_q == WhLocked) ? sel_q : sel_i;
        route_ok = (state_q != WhDrop) && (eff < SelWidth'(NumRoutes));

        if (route_ok) begin
            for (int unsigned k = 0; k < NumRoutes; k++) begin
                if (eff == SelWidth'(k)) begin
                    valid_o[k] = valid_i;
                    ready_o    = ready_i[k];
                end
            end
        end else begin
            // Discarded flits are always accepted.
            ready_o = 1'b1;
        end

        hs = valid_i & ready_o;

        unique case (state_q)
            WhIdle: begin
                if (hs) begin
                    if (route_ok) begin
                        if (!last) begin
                            sel_d   = sel_i;
                            state_d = WhLocked;
                        end
                    end else if (last) begin
                        drop_o = 1'b1;
                    end else begin
                        state_d = WhDrop;
                    end
                end
            end
            WhLocked: begin
                if (hs && last) begin
                    state_d = WhIdle;
                end
            end
            WhDrop: begin
                if (hs && last) begin
                    drop_o  = 1'b1;
                    state_d = WhIdle;
                end
            end
            default: state_d = WhIdle;
        endcase

        // Handshake outputs are held quiet while in reset; data still passes.
        if (!rst_ni) begin
            valid_o = '0;
            ready_o = 1'b0;
            drop_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= WhIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule
